// File: rtl/ds_pkg.sv
// Shared definitions for the 2x2 box-filter downsampler: SRAM mode codes,
// FSM state encoding and the rounding helper.
package ds_pkg;

  localparam logic [1:0] WE_WRITE = 2'b11;
  localparam logic [1:0] WE_READ  = 2'b00;
  localparam logic [1:0] WE_IDLE  = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_RECOV = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  // Round-to-nearest average of four 8-bit pixels; sum <= 1020 keeps it in 8 bits.
  function automatic logic [7:0] round_avg(input logic [9:0] sum);
    logic [10:0] t;
    t = {1'b0, sum} + 11'd2;
    return t[9:2];
  endfunction

endpackage

// File: rtl/ds_addr_gen.sv
// Block/pixel counters and running row bases for the downsampler. Publishes the
// addresses that will be current after this edge so the FSM can register them.
module ds_addr_gen
  import ds_pkg::*;
#(
  parameter int                IMG_W    = 256,
  parameter int                IMG_H    = 256,
  parameter int                ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] SRC_BASE = 20'h00000,
  parameter logic [ADDR_W-1:0] DST_BASE = 20'h10000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance_pixel,
  input  logic              advance_block,
  output logic [1:0]        pix_idx,
  output logic [ADDR_W-1:0] pix_addr_nxt,
  output logic [ADDR_W-1:0] dst_addr_nxt,
  output logic              last_block
);

  localparam int BX_W = $clog2(IMG_W);
  localparam int BY_W = $clog2(IMG_H);
  localparam logic [BX_W-1:0]   BX_LAST      = BX_W'(IMG_W / 2 - 1);
  localparam logic [BY_W-1:0]   BY_LAST      = BY_W'(IMG_H / 2 - 1);
  localparam logic [ADDR_W-1:0] SRC_LINE     = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] SRC_ROW_STEP = ADDR_W'(2 * IMG_W);
  localparam logic [ADDR_W-1:0] DST_ROW_STEP = ADDR_W'(IMG_W / 2);

  logic [1:0]        p_r, p_nxt_s;
  logic [BX_W-1:0]   bx_r, bx_nxt_s;
  logic [BY_W-1:0]   by_r, by_nxt_s;
  logic [ADDR_W-1:0] src_row_r, src_row_nxt_s;
  logic [ADDR_W-1:0] dst_row_r, dst_row_nxt_s;

  // Next counter and row-base values from the FSM strobes.
  always_comb begin
    p_nxt_s       = p_r;
    bx_nxt_s      = bx_r;
    by_nxt_s      = by_r;
    src_row_nxt_s = src_row_r;
    dst_row_nxt_s = dst_row_r;
    if (clear) begin
      p_nxt_s       = 2'd0;
      bx_nxt_s      = {BX_W{1'b0}};
      by_nxt_s      = {BY_W{1'b0}};
      src_row_nxt_s = SRC_BASE;
      dst_row_nxt_s = DST_BASE;
    end else if (advance_block) begin
      p_nxt_s = 2'd0;
      if (bx_r == BX_LAST) begin
        bx_nxt_s      = {BX_W{1'b0}};
        by_nxt_s      = by_r + BY_W'(1);
        src_row_nxt_s = src_row_r + SRC_ROW_STEP;
        dst_row_nxt_s = dst_row_r + DST_ROW_STEP;
      end else begin
        bx_nxt_s = bx_r + BX_W'(1);
      end
    end else if (advance_pixel) begin
      p_nxt_s = p_r + 2'd1;
    end else begin
      p_nxt_s = p_r;
    end
  end

  // Pixel p of a block: bit 0 steps one column, bit 1 steps one source line.
  always_comb begin
    pix_addr_nxt = src_row_nxt_s + ADDR_W'({bx_nxt_s, 1'b0})
                 + (p_nxt_s[1] ? SRC_LINE : {ADDR_W{1'b0}})
                 + ADDR_W'(p_nxt_s[0]);
    dst_addr_nxt = dst_row_nxt_s + ADDR_W'(bx_nxt_s);
  end

  // Counter and row-base registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_r       <= 2'd0;
      bx_r      <= {BX_W{1'b0}};
      by_r      <= {BY_W{1'b0}};
      src_row_r <= SRC_BASE;
      dst_row_r <= DST_BASE;
    end else begin
      p_r       <= p_nxt_s;
      bx_r      <= bx_nxt_s;
      by_r      <= by_nxt_s;
      src_row_r <= src_row_nxt_s;
      dst_row_r <= dst_row_nxt_s;
    end
  end

  assign pix_idx    = p_r;
  assign last_block = (bx_r == BX_LAST) && (by_r == BY_LAST);

endmodule

// File: rtl/downsample_engine.sv
// 2x2 box-filter downsampler driving an SRAM pin controller: four reads, one
// rounded average write per block. All outputs come straight from registers.
module downsample_engine
  import ds_pkg::*;
#(
  parameter int                IMG_W    = 256,
  parameter int                IMG_H    = 256,
  parameter int                ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] SRC_BASE = 20'h00000,
  parameter logic [ADDR_W-1:0] DST_BASE = 20'h10000,
  parameter int                RD_WAIT  = 2,
  parameter int                WR_HOLD  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [1:0]        sram_wr_en,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_wdata,
  input  logic [15:0]       sram_rdata
);

  if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0 || IMG_W < 2 || IMG_H < 2 ||
      RD_WAIT < 1 || WR_HOLD < 1) begin : g_bad_cfg
    $error("downsample_engine: IMG_W/IMG_H must be even and >=2, RD_WAIT/WR_HOLD >=1");
  end

  localparam logic [15:0] RD_LAST = 16'(RD_WAIT - 1);
  localparam logic [15:0] WR_LAST = 16'(WR_HOLD - 1);

  state_t            state_r, state_nxt_s;
  logic [15:0]       cnt_r, cnt_nxt_s;
  logic [9:0]        acc_r, acc_nxt_s;
  logic [1:0]        wr_en_r, wr_en_nxt_s;
  logic [ADDR_W-1:0] addr_r, addr_nxt_s;
  logic [15:0]       wdata_r, wdata_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic              done_r, done_nxt_s;

  logic              adv_pix_s, adv_blk_s, clr_s;
  logic [1:0]        pix_idx_s;
  logic [ADDR_W-1:0] pix_addr_nxt_s, dst_addr_nxt_s;
  logic              last_block_s;
  logic              rdata_hi_unused_s;

  assign rdata_hi_unused_s = ^sram_rdata[15:8];

  ds_addr_gen #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .ADDR_W  (ADDR_W),
    .SRC_BASE(SRC_BASE),
    .DST_BASE(DST_BASE)
  ) u_addr_gen (
    .clk          (clk),
    .rst          (rst),
    .clear        (clr_s),
    .advance_pixel(adv_pix_s),
    .advance_block(adv_blk_s),
    .pix_idx      (pix_idx_s),
    .pix_addr_nxt (pix_addr_nxt_s),
    .dst_addr_nxt (dst_addr_nxt_s),
    .last_block   (last_block_s)
  );

  // Next state, wait counter, accumulator and address-generator strobes.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    acc_nxt_s   = acc_r;
    adv_pix_s   = 1'b0;
    adv_blk_s   = 1'b0;
    clr_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_RD;
          cnt_nxt_s   = 16'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RD: begin
        if (cnt_r == RD_LAST) begin
          acc_nxt_s = ((pix_idx_s == 2'd0) ? 10'd0 : acc_r) + {2'b00, sram_rdata[7:0]};
          cnt_nxt_s = 16'd0;
          if (pix_idx_s == 2'd3) begin
            state_nxt_s = ST_WR_SETUP;
          end else begin
            adv_pix_s = 1'b1;
          end
        end else begin
          cnt_nxt_s = cnt_r + 16'd1;
        end
      end
      ST_WR_SETUP: begin
        state_nxt_s = ST_WR_PULSE;
        cnt_nxt_s   = 16'd0;
      end
      ST_WR_PULSE: begin
        if (cnt_r == WR_LAST) begin
          state_nxt_s = ST_WR_RECOV;
          cnt_nxt_s   = 16'd0;
        end else begin
          cnt_nxt_s = cnt_r + 16'd1;
        end
      end
      ST_WR_RECOV: begin
        cnt_nxt_s = 16'd0;
        if (last_block_s) begin
          state_nxt_s = ST_DONE;
          clr_s       = 1'b1;
        end else begin
          state_nxt_s = ST_RD;
          adv_blk_s   = 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output values for the state being entered, so registered outputs track the state.
  always_comb begin
    wr_en_nxt_s = WE_IDLE;
    addr_nxt_s  = addr_r;
    wdata_nxt_s = wdata_r;
    busy_nxt_s  = 1'b0;
    done_nxt_s  = 1'b0;
    case (state_nxt_s)
      ST_RD: begin
        wr_en_nxt_s = WE_READ;
        addr_nxt_s  = pix_addr_nxt_s;
        busy_nxt_s  = 1'b1;
      end
      ST_WR_SETUP: begin
        addr_nxt_s  = dst_addr_nxt_s;
        wdata_nxt_s = {8'h00, round_avg(acc_nxt_s)};
        busy_nxt_s  = 1'b1;
      end
      ST_WR_PULSE: begin
        wr_en_nxt_s = WE_WRITE;
        busy_nxt_s  = 1'b1;
      end
      ST_WR_RECOV: begin
        busy_nxt_s = 1'b1;
      end
      ST_DONE: begin
        done_nxt_s = 1'b1;
      end
      default: begin
        wr_en_nxt_s = WE_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any write in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 16'd0;
      acc_r   <= 10'd0;
      wr_en_r <= WE_IDLE;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= 16'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      acc_r   <= acc_nxt_s;
      wr_en_r <= wr_en_nxt_s;
      addr_r  <= addr_nxt_s;
      wdata_r <= wdata_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  assign sram_wr_en = wr_en_r;
  assign sram_addr  = addr_r;
  assign sram_wdata = wdata_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_downsample_engine.sv
// Directed bench for downsample_engine on a 4x4 image with a behavioural SRAM
// that commits a write when a full-length write pulse ends.
module tb_downsample_engine;

  localparam int          IMG_W   = 4;
  localparam int          IMG_H   = 4;
  localparam int          ADDR_W  = 20;
  localparam int          RD_WAIT = 2;
  localparam int          WR_HOLD = 2;
  localparam logic [19:0] SRC     = 20'd0;
  localparam logic [19:0] DST     = 20'd16;
  localparam int          FRAME   = (IMG_W * IMG_H / 4) * (4 * RD_WAIT + WR_HOLD + 2);

  logic              clk = 1'b0;
  logic              rst, start;
  logic              busy, done;
  logic [1:0]        sram_wr_en;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_wdata, sram_rdata;

  logic [15:0] mem [0:255];
  logic [7:0]  hi_byte = 8'h00;

  int n_tests = 0, n_fail = 0;
  int writes = 0, done_cnt = 0, busy_cycles = 0;

  typedef struct packed {
    logic [15:0][7:0] pix;   // raster order, index y*4+x
    logic [31:0]      expv;  // {blk0, blk1, blk2, blk3}
    logic [7:0]       hi;
  } vec_t;
  vec_t vecs [5];

  always #5 clk = ~clk;

  downsample_engine #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W),
    .SRC_BASE(SRC), .DST_BASE(DST), .RD_WAIT(RD_WAIT), .WR_HOLD(WR_HOLD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .sram_wr_en(sram_wr_en), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  assign sram_rdata = (sram_wr_en == 2'b00) ? {hi_byte, mem[sram_addr[7:0]][7:0]} : 16'h0000;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Four block quads {p0,p1,p2,p3} -> raster-order 4x4 image.
  function automatic logic [15:0][7:0] img(input logic [31:0] q0, q1, q2, q3);
    logic [31:0]      qs [4];
    logic [15:0][7:0] r;
    int               x, y;
    qs[0] = q0; qs[1] = q1; qs[2] = q2; qs[3] = q3;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 4; k++) begin
        x = 2 * (b % 2) + (k % 2);
        y = 2 * (b / 2) + (k / 2);
        r[y * 4 + x] = qs[b][31 - 8 * k -: 8];
      end
    end
    return r;
  endfunction

  task automatic load(input vec_t v);
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 16; i++) mem[i] = {8'h00, v.pix[i]};
    for (int i = 16; i < 20; i++) mem[i] = 16'hBEEF;
    hi_byte = v.hi;
  endtask

  // SRAM write model and write-protocol checker.
  logic        rst_q = 1'b1;
  logic [1:0]  prev_we = 2'b01;
  logic [19:0] prev_addr = 20'd0, cap_addr = 20'd0;
  logic [15:0] prev_data = 16'd0, cap_data = 16'd0;
  int          run = 0;

  always @(posedge clk) rst_q <= rst;

  always @(negedge clk) begin
    if (rst_q) begin
      run = 0;
    end else begin
      if (busy) busy_cycles++;
      if (done) done_cnt++;
      if (sram_wr_en == 2'b11) begin
        if (prev_we != 2'b11) begin
          check("pre_mode", {30'd0, prev_we}, 32'd1);
          check("pre_addr", sram_addr, prev_addr);
          check("pre_data", sram_wdata, prev_data);
          run = 1;
          cap_addr = sram_addr;
          cap_data = sram_wdata;
        end else begin
          run++;
          check("hold_addr", sram_addr, cap_addr);
          check("hold_data", sram_wdata, cap_data);
        end
      end else if (prev_we == 2'b11) begin
        check("post_mode", {30'd0, sram_wr_en}, 32'd1);
        check("hold_len", run, WR_HOLD);
        check("post_addr", sram_addr, cap_addr);
        check("post_data", sram_wdata, cap_data);
        mem[cap_addr[7:0]] = cap_data;
        writes++;
      end
    end
    prev_we   = sram_wr_en;
    prev_addr = sram_addr;
    prev_data = sram_wdata;
  end

  task automatic run_frame(input int vi, input bit mid_start, input bit done_start);
    bit seen;
    busy_cycles = 0; done_cnt = 0; writes = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("busy_rise", {31'd0, busy}, 32'd1);
    check("first_mode", {30'd0, sram_wr_en}, 32'd0);
    check("first_addr", sram_addr, SRC);
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      start = (mid_start && c == 20);
      tick;
      if (done) begin
        seen = 1'b1;
        if (done_start) begin
          start = 1'b1;
          tick;
        end
      end
    end
    start = 1'b0;
    check("done_seen", {31'd0, seen}, 32'd1);
    repeat (20) tick;
    check("busy_cycles", busy_cycles, FRAME);
    check("done_count", done_cnt, 32'd1);
    check("write_count", writes, 32'd4);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_mode", {30'd0, sram_wr_en}, 32'd1);
    for (int b = 0; b < 4; b++)
      check($sformatf("dst%0d_v%0d", b, vi), mem[16 + b], {24'd0, vecs[vi].expv[31 - 8 * b -: 8]});
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    // Identity image: block sums 10, 18, 42, 50 round to 3, 5, 11, 13.
    vecs[0] = '{pix: img(32'h00010405, 32'h02030607, 32'h08090C0D, 32'h0A0B0E0F),
                expv: 32'h03050B0D, hi: 8'h00};
    vecs[1] = '{pix: img(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF),
                expv: 32'hFFFFFFFF, hi: 8'h00};
    vecs[2] = '{pix: img(32'h01000000, 32'h01010000, 32'h02000000, 32'h03030302),
                expv: 32'h00010103, hi: 8'h00};
    vecs[3] = '{pix: img(32'h00010405, 32'h02030607, 32'h08090C0D, 32'h0A0B0E0F),
                expv: 32'h03050B0D, hi: 8'hAA};
    vecs[4] = '{pix: img(32'hFFFFFFFE, 32'h00000001, 32'h02020201, 32'h807F807F),
                expv: 32'hFF000280, hi: 8'h55};

    rst = 1'b1;
    start = 1'b0;
    load(vecs[0]);
    repeat (3) tick;
    check("rst_mode", {30'd0, sram_wr_en}, 32'd1);
    check("rst_addr", sram_addr, 32'd0);
    check("rst_wdata", sram_wdata, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    tick;

    for (int vi = 0; vi < 5; vi++) begin
      load(vecs[vi]);
      run_frame(vi, 1'b0, 1'b0);
    end

    // Reset during the second block's write pulse.
    load(vecs[0]);
    writes = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      tick;
      if (sram_wr_en == 2'b11 && sram_addr == 20'd17) found = 1'b1;
    end
    check("find_pulse", {31'd0, found}, 32'd1);
    rst = 1'b1;
    tick;
    check("abort_mode", {30'd0, sram_wr_en}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_addr", sram_addr, 32'd0);
    rst = 1'b0;
    repeat (5) tick;
    check("abort_writes", writes, 32'd1);
    check("abort_mem16", mem[16], 32'h0003);
    check("abort_mem17", mem[17], 32'hBEEF);
    load(vecs[0]);
    run_frame(0, 1'b0, 1'b0);

    // Start pulses mid-frame and during the DONE cycle are ignored.
    load(vecs[2]);
    run_frame(2, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
